// File: rtl/l2_cache_pkg.sv
// Shared types and geometry helpers for the direct-mapped L2 cache.
// Line offset width is fixed; tag and index widths follow from the parameters.
package l2_types;

   localparam int OFFSET_W = 5;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      CHECK     = 2'd1,
      WRITEBACK = 2'd2,
      FILL      = 2'd3
   } l2_state_e;

   function automatic int tag_width(input int addr_w, input int s_index);
      return addr_w - OFFSET_W - s_index;
   endfunction

   function automatic int index_width(input int s_index);
      return s_index;
   endfunction

   function automatic int line_bytes(input int line_w);
      return line_w / 8;
   endfunction

endpackage

// File: rtl/l2_cache_array.sv
// Per-set valid/dirty/tag/data storage with one combinational read port
// and one byte-masked write port sharing the same set index.
module l2_array
   import l2_types::*;
#(
   parameter int S_INDEX = 3,
   parameter int TAG_W   = 24,
   parameter int LINE_W  = 256
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [S_INDEX-1:0]             idx,
   output logic                           rd_valid,
   output logic                           rd_dirty,
   output logic [TAG_W-1:0]               rd_tag,
   output logic [LINE_W-1:0]              rd_data,
   input  logic                           data_we,
   input  logic [line_bytes(LINE_W)-1:0]  data_be,
   input  logic [LINE_W-1:0]              data_wdata,
   input  logic                           tag_we,
   input  logic [TAG_W-1:0]               tag_wdata,
   input  logic                           dirty_we,
   input  logic                           dirty_wdata
);

   localparam int SETS = 2 ** S_INDEX;
   localparam int BE_W = line_bytes(LINE_W);

   logic [SETS-1:0]   valid_r;
   logic [SETS-1:0]   dirty_r;
   logic [TAG_W-1:0]  tag_r  [SETS];
   logic [LINE_W-1:0] data_r [SETS];
   logic [LINE_W-1:0] merged_s;

   assign rd_valid = valid_r[idx];
   assign rd_dirty = dirty_r[idx];
   assign rd_tag   = tag_r[idx];
   assign rd_data  = data_r[idx];

   // Byte merge of incoming write data over the currently stored line
   always_comb begin
      merged_s = data_r[idx];
      for (int b = 0; b < BE_W; b++) begin
         if (data_be[b]) begin
            merged_s[8*b +: 8] = data_wdata[8*b +: 8];
         end else begin
            merged_s[8*b +: 8] = data_r[idx][8*b +: 8];
         end
      end
   end

   // Valid/dirty flags: the only storage that must come out of reset known
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_r <= '0;
         dirty_r <= '0;
      end else begin
         if (tag_we) begin
            valid_r[idx] <= 1'b1;
         end
         if (dirty_we) begin
            dirty_r[idx] <= dirty_wdata;
         end
      end
   end

   // Tag and data payload, contents undefined until first fill
   always_ff @(posedge clk) begin
      if (data_we) begin
         data_r[idx] <= merged_s;
      end
      if (tag_we) begin
         tag_r[idx] <= tag_wdata;
      end
   end

endmodule

// File: rtl/l2_cache.sv
// Direct-mapped write-back/write-allocate L2: request FSM, address muxing and
// registered upstream/downstream outputs around the l2_array storage.
module l2_cache
   import l2_types::*;
#(
   parameter int S_INDEX = 3,
   parameter int ADDR_W  = 32,
   parameter int LINE_W  = 256
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   mem_read,
   input  logic                   mem_write,
   input  logic [ADDR_W-1:0]      mem_address,
   input  logic [LINE_W-1:0]      mem_wdata,
   input  logic [LINE_W/8-1:0]    mem_byte_enable,
   output logic [LINE_W-1:0]      mem_rdata,
   output logic                   mem_resp,
   output logic                   pmem_read,
   output logic                   pmem_write,
   output logic [ADDR_W-1:0]      pmem_address,
   output logic [LINE_W-1:0]      pmem_wdata,
   input  logic [LINE_W-1:0]      pmem_rdata,
   input  logic                   pmem_resp
);

   localparam int TAG_W = tag_width(ADDR_W, S_INDEX);
   localparam int IDX_W = index_width(S_INDEX);
   localparam int BE_W  = line_bytes(LINE_W);

   l2_state_e           state_r, next_state_s;
   logic [TAG_W-1:0]    req_tag_r;
   logic [IDX_W-1:0]    req_idx_r;
   logic [LINE_W-1:0]   req_wdata_r;
   logic [BE_W-1:0]     req_be_r;
   logic                req_write_r;

   logic                req_s, hit_s, unused_ok_s;
   logic [TAG_W-1:0]    in_tag_s, lk_tag_s;
   logic [IDX_W-1:0]    in_idx_s, idx_s;
   logic                rd_valid_s, rd_dirty_s;
   logic [TAG_W-1:0]    rd_tag_s;
   logic [LINE_W-1:0]   rd_data_s;

   logic                data_we_s, tag_we_s, dirty_we_s, dirty_wdata_s;
   logic [BE_W-1:0]     data_be_s;
   logic [LINE_W-1:0]   data_wdata_s;

   logic                mem_resp_r, pmem_read_r, pmem_write_r;
   logic [LINE_W-1:0]   mem_rdata_r, pmem_wdata_r;
   logic [ADDR_W-1:0]   pmem_address_r;
   logic                mem_resp_nx_s;
   logic [LINE_W-1:0]   mem_rdata_nx_s, pmem_wdata_nx_s;
   logic [ADDR_W-1:0]   pmem_address_nx_s;

   assign req_s       = mem_read | mem_write;
   assign in_tag_s    = mem_address[ADDR_W-1 -: TAG_W];
   assign in_idx_s    = mem_address[OFFSET_W +: IDX_W];
   assign unused_ok_s = ^mem_address[OFFSET_W-1:0];

   // In IDLE the array is looked up with the incoming address so the hit
   // response can be registered into the CHECK cycle
   always_comb begin
      if (state_r == IDLE) begin
         idx_s    = in_idx_s;
         lk_tag_s = in_tag_s;
      end else begin
         idx_s    = req_idx_r;
         lk_tag_s = req_tag_r;
      end
   end

   assign hit_s = rd_valid_s && (rd_tag_s == lk_tag_s);

   l2_array #(
      .S_INDEX (S_INDEX),
      .TAG_W   (TAG_W),
      .LINE_W  (LINE_W)
   ) u_array (
      .clk         (clk),
      .rst_n       (rst_n),
      .idx         (idx_s),
      .rd_valid    (rd_valid_s),
      .rd_dirty    (rd_dirty_s),
      .rd_tag      (rd_tag_s),
      .rd_data     (rd_data_s),
      .data_we     (data_we_s),
      .data_be     (data_be_s),
      .data_wdata  (data_wdata_s),
      .tag_we      (tag_we_s),
      .tag_wdata   (req_tag_r),
      .dirty_we    (dirty_we_s),
      .dirty_wdata (dirty_wdata_s)
   );

   // Next-state and array write controls
   always_comb begin
      next_state_s  = state_r;
      data_we_s     = 1'b0;
      data_be_s     = req_be_r;
      data_wdata_s  = req_wdata_r;
      tag_we_s      = 1'b0;
      dirty_we_s    = 1'b0;
      dirty_wdata_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (req_s) begin
               next_state_s = CHECK;
            end else begin
               next_state_s = IDLE;
            end
         end
         CHECK: begin
            if (hit_s) begin
               next_state_s = IDLE;
               if (req_write_r) begin
                  data_we_s     = 1'b1;
                  dirty_we_s    = 1'b1;
                  dirty_wdata_s = 1'b1;
               end else begin
                  data_we_s     = 1'b0;
               end
            end else if (rd_valid_s && rd_dirty_s) begin
               next_state_s = WRITEBACK;
            end else begin
               next_state_s = FILL;
            end
         end
         WRITEBACK: begin
            if (pmem_resp) begin
               dirty_we_s   = 1'b1;
               next_state_s = FILL;
            end else begin
               next_state_s = WRITEBACK;
            end
         end
         FILL: begin
            if (pmem_resp) begin
               data_we_s    = 1'b1;
               data_be_s    = '1;
               data_wdata_s = pmem_rdata;
               tag_we_s     = 1'b1;
               dirty_we_s   = 1'b1;
               next_state_s = CHECK;
            end else begin
               next_state_s = FILL;
            end
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   // Output values for the coming cycle; a fill always makes CHECK hit
   always_comb begin
      mem_resp_nx_s     = 1'b0;
      mem_rdata_nx_s    = '0;
      pmem_address_nx_s = '0;
      pmem_wdata_nx_s   = '0;
      if ((state_r == IDLE) && req_s && hit_s) begin
         mem_resp_nx_s  = 1'b1;
         mem_rdata_nx_s = rd_data_s;
      end else if ((state_r == FILL) && pmem_resp) begin
         mem_resp_nx_s  = 1'b1;
         mem_rdata_nx_s = pmem_rdata;
      end else begin
         mem_resp_nx_s  = 1'b0;
      end
      if (next_state_s == WRITEBACK) begin
         pmem_address_nx_s = {rd_tag_s, req_idx_r, {OFFSET_W{1'b0}}};
         pmem_wdata_nx_s   = rd_data_s;
      end else if (next_state_s == FILL) begin
         pmem_address_nx_s = {req_tag_r, req_idx_r, {OFFSET_W{1'b0}}};
      end else begin
         pmem_address_nx_s = '0;
      end
   end

   // State, request latch and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r        <= IDLE;
         req_tag_r      <= '0;
         req_idx_r      <= '0;
         req_wdata_r    <= '0;
         req_be_r       <= '0;
         req_write_r    <= 1'b0;
         mem_resp_r     <= 1'b0;
         mem_rdata_r    <= '0;
         pmem_read_r    <= 1'b0;
         pmem_write_r   <= 1'b0;
         pmem_address_r <= '0;
         pmem_wdata_r   <= '0;
      end else begin
         state_r <= next_state_s;
         if ((state_r == IDLE) && req_s) begin
            req_tag_r   <= in_tag_s;
            req_idx_r   <= in_idx_s;
            req_wdata_r <= mem_wdata;
            req_be_r    <= mem_byte_enable;
            req_write_r <= mem_write;
         end
         mem_resp_r     <= mem_resp_nx_s;
         mem_rdata_r    <= mem_rdata_nx_s;
         pmem_read_r    <= (next_state_s == FILL);
         pmem_write_r   <= (next_state_s == WRITEBACK);
         pmem_address_r <= pmem_address_nx_s;
         pmem_wdata_r   <= pmem_wdata_nx_s;
      end
   end

   assign mem_resp     = mem_resp_r;
   assign mem_rdata    = mem_rdata_r;
   assign pmem_read    = pmem_read_r;
   assign pmem_write   = pmem_write_r;
   assign pmem_address = pmem_address_r;
   assign pmem_wdata   = pmem_wdata_r;

endmodule

// File: tb/tb_l2_cache.sv
// Bench for l2_cache: directed scenarios then random traffic, checked against
// a set-array and backing-memory reference model with a delayed memory responder.
module tb_l2_cache;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           mem_read, mem_write;
   logic [31:0]    mem_address;
   logic [255:0]   mem_wdata;
   logic [31:0]    mem_byte_enable;
   logic [255:0]   mem_rdata;
   logic           mem_resp;
   logic           pmem_read, pmem_write;
   logic [31:0]    pmem_address;
   logic [255:0]   pmem_wdata;
   logic [255:0]   pmem_rdata;
   logic           pmem_resp;

   always #5 clk = ~clk;

   l2_cache #(.S_INDEX(3), .ADDR_W(32), .LINE_W(256)) dut (
      .clk(clk), .rst_n(rst_n),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
      .mem_rdata(mem_rdata), .mem_resp(mem_resp),
      .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
      .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model: cache sets plus a sparse backing memory
   bit             m_valid [8];
   bit             m_dirty [8];
   logic [23:0]    m_tag   [8];
   logic [255:0]   m_data  [8];
   logic [255:0]   mem_m   [logic [31:0]];

   task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [255:0] rand_line();
      logic [255:0] l;
      for (int w = 0; w < 8; w++) l[32*w +: 32] = $urandom();
      return l;
   endfunction

   function automatic logic [255:0] mem_get(input logic [31:0] a);
      if (!mem_m.exists(a)) mem_m[a] = rand_line();
      return mem_m[a];
   endfunction

   function automatic logic [255:0] merge(input logic [255:0] old_l, input logic [255:0] new_l,
                                          input logic [31:0] be);
      logic [255:0] r = old_l;
      for (int b = 0; b < 32; b++) if (be[b]) r[8*b +: 8] = new_l[8*b +: 8];
      return r;
   endfunction

   // One arbiter request from the negedge it is driven to the negedge after the pulse
   task automatic run_req(input logic [31:0] addr, input bit rd, input bit wr,
                          input logic [255:0] wd, input logic [31:0] be, input int dly,
                          output logic [255:0] rdata_o, output bit fill_o);
      logic [23:0]  t;
      logic [2:0]   ix;
      logic [31:0]  line_a, wb_a;
      logic [255:0] wb_d, line_d;
      bit           hit, got, txn_open;
      int           phase, wcnt, resp_cyc, cyc;
      t       = addr[31:8];
      ix      = addr[7:5];
      line_a  = {addr[31:5], 5'b0};
      hit     = m_valid[ix] && (m_tag[ix] == t);
      phase   = hit ? 2 : ((m_valid[ix] && m_dirty[ix]) ? 0 : 1);
      wb_a    = {m_tag[ix], ix, 5'b0};
      wb_d    = m_data[ix];
      line_d  = hit ? m_data[ix] : mem_get(line_a);
      rdata_o = '0;
      fill_o  = 1'b0;
      got = 1'b0; txn_open = 1'b0; wcnt = 0; resp_cyc = -100; cyc = 0;
      mem_read = rd; mem_write = wr; mem_address = addr;
      mem_wdata = wd; mem_byte_enable = be;
      while (!got && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (pmem_read && pmem_write) chk("pmem_excl", 256'd1, 256'd0);
         if (pmem_resp) begin
            pmem_resp = 1'b0;
         end else if (pmem_read || pmem_write) begin
            if (!txn_open) begin
               txn_open = 1'b1;
               wcnt = dly;
               if (pmem_write) begin
                  chk("wb_order", phase, 0);
                  chk("wb_addr", pmem_address, wb_a);
                  chk("wb_data", pmem_wdata, wb_d);
                  phase = 1;
               end else begin
                  chk("fill_order", phase, 1);
                  chk("fill_addr", pmem_address, line_a);
                  phase = 2;
                  fill_o = 1'b1;
               end
            end
            if (wcnt == 0) begin
               pmem_resp  = 1'b1;
               pmem_rdata = pmem_write ? rand_line() : line_d;
               txn_open   = 1'b0;
               resp_cyc   = cyc;
            end else begin
               wcnt--;
            end
         end
         if (mem_resp) begin
            got = 1'b1;
            chk("resp_latency", cyc, hit ? 1 : resp_cyc + 1);
            chk("resp_phase", phase, 2);
            if (!wr) chk("rdata", mem_rdata, line_d);
            rdata_o = mem_rdata;
         end
      end
      if (!got) chk("resp_timeout", got, 1'b1);
      if (!hit) begin
         if (m_valid[ix] && m_dirty[ix]) mem_m[wb_a] = wb_d;
         m_valid[ix] = 1'b1;
         m_dirty[ix] = 1'b0;
         m_tag[ix]   = t;
         m_data[ix]  = line_d;
      end
      if (wr) begin
         m_data[ix]  = merge(m_data[ix], wd, be);
         m_dirty[ix] = 1'b1;
      end
      mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
      @(negedge clk);
      chk("resp_single", mem_resp, 1'b0);
      chk("pmem_idle", {pmem_read, pmem_write}, 2'b00);
   endtask

   initial begin
      logic [255:0] rd, wd;
      logic [31:0]  addr, be;
      bit           f;
      int           k;
      rst_n = 1'b0;
      mem_read = 1'b0; mem_write = 1'b0; mem_address = '0;
      mem_wdata = '0; mem_byte_enable = '0;
      pmem_rdata = '0; pmem_resp = 1'b0;
      for (int i = 0; i < 8; i++) begin m_valid[i] = 1'b0; m_dirty[i] = 1'b0; end
      #3;
      chk("rst_mem_resp", mem_resp, 1'b0);
      chk("rst_pmem_req", {pmem_read, pmem_write}, 2'b00);
      chk("rst_pmem_addr", pmem_address, 32'h0);
      chk("rst_rdata", mem_rdata, 256'h0);
      chk("rst_wdata", pmem_wdata, 256'h0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run_req(32'h0000_1044, 1'b1, 1'b0, '0, 32'h0, 4, rd, f);
      chk("cold_miss_fill", f, 1'b1);
      run_req(32'h0000_1040, 1'b1, 1'b0, '0, 32'h0, 4, rd, f);
      chk("hit_no_fill", f, 1'b0);
      wd = rand_line();
      wd[31:0] = 32'hDEADBEEF;
      run_req(32'h0000_1040, 1'b0, 1'b1, wd, 32'h0000_000F, 2, rd, f);
      chk("write_hit_no_fill", f, 1'b0);
      run_req(32'h0000_1040, 1'b1, 1'b0, '0, 32'h0, 2, rd, f);
      chk("merge_low_word", rd[31:0], 32'hDEADBEEF);
      run_req(32'h0000_2040, 1'b1, 1'b0, '0, 32'h0, 3, rd, f);
      chk("evict_fill", f, 1'b1);

      // Reset in the middle of a fill on another set
      mem_read = 1'b1; mem_address = 32'h0000_3060;
      k = 0;
      while (!pmem_read && k < 20) begin @(negedge clk); k++; end
      chk("mid_fill_req", pmem_read, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_async_read", pmem_read, 1'b0);
      chk("rst_async_addr", pmem_address, 32'h0);
      mem_read = 1'b0;
      for (int i = 0; i < 8; i++) begin m_valid[i] = 1'b0; m_dirty[i] = 1'b0; end
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_req(32'h0000_2040, 1'b1, 1'b0, '0, 32'h0, 1, rd, f);
      chk("post_rst_miss", f, 1'b1);

      // Read and write together on a hit behave as a write
      wd = rand_line();
      run_req(32'h0000_2040, 1'b1, 1'b1, wd, 32'hF0F0_00FF, 1, rd, f);
      chk("rw_hit_no_fill", f, 1'b0);
      run_req(32'h0000_1040, 1'b1, 1'b0, '0, 32'h0, 1, rd, f);
      chk("rw_dirty_evict", f, 1'b1);

      for (int n = 0; n < 200; n++) begin
         addr = {22'h0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 5'($urandom())};
         be   = $urandom();
         case ($urandom_range(0, 2))
            0: run_req(addr, 1'b1, 1'b0, '0, be, $urandom_range(0, 5), rd, f);
            1: run_req(addr, 1'b0, 1'b1, rand_line(), be, $urandom_range(0, 5), rd, f);
            default: run_req(addr, 1'b1, 1'b1, rand_line(), be, $urandom_range(0, 5), rd, f);
         endcase
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
